// File: rtl/riscv_regfile_sb_if.sv
// Interface bundling the regfile/scoreboard bus: read ports, writeback, allocation and flush.
// master = decode/writeback side, slave = register file.
interface riscv_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD-1:0][AW-1:0]   rd_addr;
  logic [NREAD-1:0][XLEN-1:0] rd_data;
  logic [NREAD-1:0]           rd_ready;
  logic                       wr_en;
  logic [AW-1:0]              wr_addr;
  logic [XLEN-1:0]            wr_data;
  logic                       alloc_en;
  logic [AW-1:0]              alloc_addr;
  logic                       flush;
  logic [AW:0]                busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_ready, busy_cnt
  );
endinterface

// File: rtl/riscv_regfile_sb.sv
// Integer register file (NREAD read ports, one write port) with per-register busy scoreboard.
// Optional same-cycle write forwarding to the read ports: define REGFILE_BYPASS_EN.
module riscv_regfile_sb_rport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]              addr,
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [NREGS-1:0]           busy,
  input  logic                       fwd_en,
  input  logic [AW-1:0]              fwd_addr,
  input  logic [XLEN-1:0]            fwd_data,
  output logic [XLEN-1:0]            data,
  output logic                       ready
);
  logic hit;

  // x0 never forwards; regs[0]/busy[0] are held at zero so plain indexing covers it.
  assign hit   = fwd_en && (fwd_addr == addr) && (addr != '0);
  assign data  = hit ? fwd_data : regs[addr];
  assign ready = hit | ~busy[addr];
endmodule

module riscv_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  riscv_regfile_sb_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy, busy_nxt;
  logic [AW:0]                cnt_nxt, busy_cnt;
  logic                       wr_ok, alloc_ok, fwd_en;

  assign wr_ok    = bus.wr_en    && (bus.wr_addr    != '0);
  assign alloc_ok = bus.alloc_en && (bus.alloc_addr != '0);

`ifdef REGFILE_BYPASS_EN
  assign fwd_en = wr_ok;
`else
  assign fwd_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n)   regs <= '0;
    else if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
  end

  // Apply lowest priority first so alloc overrides release/flush on the same bit.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) busy_nxt = '0;
    if (wr_ok)     busy_nxt[bus.wr_addr] = 1'b0;
    if (alloc_ok)  busy_nxt[bus.alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Count is recomputed from the next vector rather than inc/dec'd, so it cannot drift.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = busy_cnt;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    riscv_regfile_sb_rport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rport (
      .addr     (bus.rd_addr[i]),
      .regs     (regs),
      .busy     (busy),
      .fwd_en   (fwd_en),
      .fwd_addr (bus.wr_addr),
      .fwd_data (bus.wr_data),
      .data     (bus.rd_data[i]),
      .ready    (bus.rd_ready[i])
    );
  end
endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed table-driven bench for riscv_regfile_sb (XLEN=32, NREGS=32, NREAD=2).
// Outputs are checked 1ns after the negedge input update, i.e. the pre-posedge view.
module tb_riscv_regfile_sb;
  logic clk = 1'b0;
  logic reset_n;

  riscv_regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus();

  riscv_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [4:0]  ra0, ra1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ae;
    logic [4:0]  aa;
    logic        fl;
    logic [31:0] ed0, ed1;
    logic [1:0]  erdy;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic rst_n, logic [4:0] ra0, logic [4:0] ra1,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic ae, logic [4:0] aa, logic fl,
                              logic [31:0] ed0, logic [31:0] ed1,
                              logic [1:0] erdy, logic [5:0] ecnt);
    vec_t v;
    v.rst_n = rst_n; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd;
    v.ae = ae; v.aa = aa; v.fl = fl; v.ed0 = ed0; v.ed1 = ed1; v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    reset_n         = v.rst_n;
    bus.rd_addr[0]  = v.ra0;
    bus.rd_addr[1]  = v.ra1;
    bus.wr_en       = v.we;
    bus.wr_addr     = v.wa;
    bus.wr_data     = v.wd;
    bus.alloc_en    = v.ae;
    bus.alloc_addr  = v.aa;
    bus.flush       = v.fl;
    #1;
    chk("rd_data0", idx, bus.rd_data[0], v.ed0);
    chk("rd_data1", idx, bus.rd_data[1], v.ed1);
    chk("rd_ready", idx, {30'd0, bus.rd_ready}, {30'd0, v.erdy});
    chk("busy_cnt", idx, {26'd0, bus.busy_cnt}, {26'd0, v.ecnt});
  endtask

  initial begin
    reset_n = 1'b0;
    bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);

    //          rst ra0 ra1 we wa  wd            ae aa  fl  ed0           ed1          rdy    cnt
    // reset after writes/allocs; reset beats same-cycle write and alloc
    tbl.push_back(mk(1, 0,  8, 1, 5,  32'hAAAA0005, 1, 8,  0, 32'h0,        32'h0,        2'b11, 0));
    tbl.push_back(mk(1, 5,  8, 1, 6,  32'h00006666, 0, 0,  0, 32'hAAAA0005, 32'h0,        2'b01, 1));
    tbl.push_back(mk(0, 5,  6, 1, 9,  32'h00000099, 1, 10, 0, 32'hAAAA0005, 32'h00006666, 2'b11, 1));
    tbl.push_back(mk(1, 5,  6, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b11, 0));
    tbl.push_back(mk(1, 9,  10,0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b11, 0));
    // write x5, write x0 ignored
    tbl.push_back(mk(1, 0,  0, 1, 5,  32'hDEADBEEF, 0, 0,  0, 32'h0,        32'h0,        2'b11, 0));
    tbl.push_back(mk(1, 5,  0, 1, 0,  32'h00001234, 0, 0,  0, 32'hDEADBEEF, 32'h0,        2'b11, 0));
    tbl.push_back(mk(1, 0,  5, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'hDEADBEEF, 2'b11, 0));
    // alloc x7 then release by write
    tbl.push_back(mk(1, 5,  0, 0, 0,  32'h0,        1, 7,  0, 32'hDEADBEEF, 32'h0,        2'b11, 0));
    tbl.push_back(mk(1, 7,  0, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b10, 1));
    tbl.push_back(mk(1, 0,  0, 1, 7,  32'h00000055, 0, 0,  0, 32'h0,        32'h0,        2'b11, 1));
    tbl.push_back(mk(1, 7,  7, 0, 0,  32'h0,        0, 0,  0, 32'h55,       32'h55,       2'b11, 0));
    // busy x3, then same-cycle write+alloc x3: new producer wins; alloc x0 ignored
    tbl.push_back(mk(1, 3,  0, 0, 0,  32'h0,        1, 3,  0, 32'h0,        32'h0,        2'b11, 0));
    tbl.push_back(mk(1, 0,  0, 1, 3,  32'h0000000A, 1, 3,  0, 32'h0,        32'h0,        2'b11, 1));
    tbl.push_back(mk(1, 3,  0, 0, 0,  32'h0,        0, 0,  0, 32'hA,        32'h0,        2'b10, 1));
    tbl.push_back(mk(1, 0,  3, 0, 0,  32'h0,        1, 0,  0, 32'h0,        32'hA,        2'b01, 1));
    tbl.push_back(mk(1, 0,  0, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b11, 1));
    // alloc x1,x2,x4 then flush + alloc x9
    tbl.push_back(mk(1, 1,  3, 0, 0,  32'h0,        1, 1,  0, 32'h0,        32'hA,        2'b01, 1));
    tbl.push_back(mk(1, 1,  2, 0, 0,  32'h0,        1, 2,  0, 32'h0,        32'h0,        2'b10, 2));
    tbl.push_back(mk(1, 2,  4, 0, 0,  32'h0,        1, 4,  0, 32'h0,        32'h0,        2'b10, 3));
    tbl.push_back(mk(1, 4,  3, 0, 0,  32'h0,        1, 9,  1, 32'h0,        32'hA,        2'b00, 4));
    tbl.push_back(mk(1, 9,  1, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b10, 1));
    tbl.push_back(mk(1, 2,  4, 0, 0,  32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b11, 1));
    // simultaneous release x9 / alloc x11: count must not drift
    tbl.push_back(mk(1, 3,  0, 1, 9,  32'h00000009, 1, 11, 0, 32'hA,        32'h0,        2'b11, 1));
    tbl.push_back(mk(1, 9,  11,0, 0,  32'h0,        0, 0,  0, 32'h9,        32'h0,        2'b01, 1));
    // flush with same-cycle write still writes data
    tbl.push_back(mk(1, 0,  0, 1, 12, 32'h0000000C, 0, 0,  1, 32'h0,        32'h0,        2'b11, 1));
    tbl.push_back(mk(1, 12, 11,0, 0,  32'h0,        0, 0,  0, 32'hC,        32'h0,        2'b11, 0));

    foreach (tbl[i]) step(tbl[i], i);

    // read-during-write on x6 (busy), then write+alloc x6 while reading it
    step(mk(1, 6, 6, 0, 0, 32'h0,  1, 6, 0, 32'h0,  32'h0,  2'b11, 0), 100);
`ifdef REGFILE_BYPASS_EN
    step(mk(1, 6, 6, 1, 6, 32'h77, 0, 0, 0, 32'h77, 32'h77, 2'b11, 1), 101);
`else
    step(mk(1, 6, 6, 1, 6, 32'h77, 0, 0, 0, 32'h0,  32'h0,  2'b00, 1), 101);
`endif
    step(mk(1, 6, 6, 0, 0, 32'h0,  0, 0, 0, 32'h77, 32'h77, 2'b11, 0), 102);
`ifdef REGFILE_BYPASS_EN
    step(mk(1, 6, 6, 1, 6, 32'h88, 1, 6, 0, 32'h88, 32'h88, 2'b11, 0), 103);
`else
    step(mk(1, 6, 6, 1, 6, 32'h88, 1, 6, 0, 32'h77, 32'h77, 2'b11, 0), 103);
`endif
    step(mk(1, 6, 6, 0, 0, 32'h0,  0, 0, 0, 32'h88, 32'h88, 2'b00, 1), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
